seq_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the datapath ALU, producing a 2×WIDTH result split into HI and LO for loading into the HI/LO registers. It handles signed and unsigned multiply and divide through one iterative magnitude engine, with a single sign fix-up step at the end. A start/busy/done handshake lets the control unit stall while an operation runs, replacing single-cycle combinational multiply.

---
 rtl/seq_muldiv_pkg.sv | 18 +
 rtl/seq_muldiv_if.sv | 30 +++
 rtl/seq_muldiv_div_step.sv | 22 ++
 rtl/seq_muldiv.sv | 150 +++++++++++++++
 tb/tb_seq_muldiv.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seq_muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation encodings and the controller state type.
package muldiv_pkg;

    // Operation encodings: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_muldiv_if.sv
// Request/result bundle between the control unit and seq_muldiv.
//
// Handshake: start is sampled only while the unit is idle; operands and op
// are captured on that edge. busy is high from the cycle after acceptance
// until the result is ready. done is a one-cycle pulse with hi/lo/div_by_zero
// valid; those outputs then hold until the next result or a clear. start
// seen while busy or during the done cycle is dropped, never queued.
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/seq_muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The remainder stays below the divisor, so the difference fits WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted[WIDTH-1:0] - divisor_i;
        q_o     = (shifted >= {1'b0, divisor_i});
        rem_o   = q_o ? diff : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit. Operands are reduced to magnitudes on
// capture, one shift-add or restoring step runs per cycle for WIDTH cycles,
// and a single FIXUP cycle applies signs before the result is registered.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clock,
    input  logic         clear,
    seq_muldiv_if.slave  bus,
    output state_t       dbg_state_o
);
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    // High half: MUL partial product / DIV remainder.
    // Low half: MUL multiplier being consumed / DIV dividend becoming quotient.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   a_orig_q;
    logic               neg_res_q;   // negate product / quotient
    logic               neg_rem_q;   // negate remainder
    logic               dbz_pend_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic               div_q;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               dbz_d;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .divisor_i (opnd_q),
        .bit_i     (acc_q[WIDTH-1]),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    // Operand magnitudes; unsigned ops pass values through untouched.
    always_comb begin
        a_mag = (!bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (!bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        step_next = op_q[1] ? {div_rem, acc_q[WIDTH-2:0], div_q}
                            : {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Sign fix-up and divide-by-zero override for the final result.
    always_comb begin
        prod  = neg_res_q ? -acc_q : acc_q;
        quo   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        hi_d  = prod[2*WIDTH-1:WIDTH];
        lo_d  = prod[WIDTH-1:0];
        dbz_d = 1'b0;
        if (op_q[1]) begin
            if (dbz_pend_q) begin
                hi_d  = a_orig_q;
                lo_d  = {WIDTH{1'b1}};
                dbz_d = 1'b1;
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end
    end

    // Controller and datapath registers; clear aborts any operation.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_orig_q   <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q       <= bus.op;
                        acc_q      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        opnd_q     <= bus.op[1] ? b_mag : a_mag;
                        a_orig_q   <= bus.a;
                        neg_res_q  <= !bus.op[0] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_q  <= (bus.op == OP_DIV) && bus.a[WIDTH-1];
                        dbz_pend_q <= bus.op[1] && (bus.b == '0);
                        cnt_q      <= CNT_W'(WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dbz_q   <= dbz_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv (WIDTH=32): hand-computed results, latency,
// busy/done shape, ignored starts, mid-operation clear and back-to-back.
module tb_seq_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic   clock;
    logic   clear;
    state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W:0] exp_q[$];

    seq_muldiv_if #(.WIDTH(W)) bus ();

    seq_muldiv #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one op at the next negedge; optionally pulse a second start with
    // other operands at cycle poke_at. Checks latency, busy, done and result.
    task automatic run_op(input logic [1:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_dbz, input int poke_at);
        int   c;
        logic busy_ok;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        @(negedge clock);
        bus.start = 1'b0;
        c = 1;
        busy_ok = 1'b1;
        while (!bus.done && c < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (c == poke_at) begin
                bus.start = 1'b1;
                bus.op    = OP_MULU;
                bus.a     = 32'h0000_1234;
                bus.b     = 32'h0000_0002;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
            c++;
        end
        bus.start = 1'b0;
        check("latency", c, 34);
        check("busy_during_run", busy_ok, 1'b1);
        check("busy_at_done", bus.busy, 1'b0);
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
        check("div_by_zero", bus.div_by_zero, exp_dbz);
        @(negedge clock);
        check("done_pulse_width", bus.done, 1'b0);
        check("hold_lo", bus.lo, exp_lo);
    endtask

    // Stimulus and checks
    initial begin
        logic [1:0]   v_op[4];
        logic [W-1:0] v_a[4];
        logic [W-1:0] v_b[4];
        logic [2*W:0] got;
        logic [2*W:0] exp;
        logic         done_seen;
        int           cyc;
        int           last;
        int           seen;

        clear     = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clock);
        bus.start = 1'b0;
        clear     = 1'b0;

        // Reset state (start held during clear must not launch anything)
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        check("rst_state", dbg_state, IDLE);

        // Directed results
        run_op(OP_MUL,  32'h7000_0000, 32'h0000_0008, 32'h0000_0003, 32'h8000_0000, 1'b0, -1);
        run_op(OP_MUL,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        run_op(OP_MULU, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, -1);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, -1);
        run_op(OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, -1);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1);
        // Second start at cycle 5 is ignored
        run_op(OP_MUL,  32'h0000_0064, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FF38, 1'b0, 5);

        // Clear at cycle 10 of a new operation
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_MULU;
        bus.a     = 32'h0000_0003;
        bus.b     = 32'h0000_0005;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_busy", bus.busy, 1'b0);
        check("clr_hi", bus.hi, '0);
        check("clr_lo", bus.lo, '0);
        check("clr_state", dbg_state, IDLE);
        done_seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) done_seen = 1'b1;
        end
        check("clr_no_done", done_seen, 1'b0);

        // Back-to-back with start held high
        v_op[0] = OP_MULU; v_a[0] = 32'h1234_5678; v_b[0] = 32'h0000_0010;
        v_op[1] = OP_DIVU; v_a[1] = 32'd1000;      v_b[1] = 32'd7;
        v_op[2] = OP_DIV;  v_a[2] = 32'd7;         v_b[2] = 32'hFFFF_FFFE;
        v_op[3] = OP_MUL;  v_a[3] = 32'hFFFF_FFFF; v_b[3] = 32'hFFFF_FFFF;
        exp_q.push_back({1'b0, 32'h0000_0001, 32'h2345_6780});
        exp_q.push_back({1'b0, 32'h0000_0006, 32'h0000_008E});
        exp_q.push_back({1'b0, 32'h0000_0001, 32'hFFFF_FFFD});
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0000_0001});

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = v_op[0];
        bus.a     = v_a[0];
        bus.b     = v_b[0];
        cyc  = 0;
        last = 0;
        seen = 0;
        while (seen < 4 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (bus.done) begin
                got = {bus.div_by_zero, bus.hi, bus.lo};
                exp = exp_q.pop_front();
                check("b2b_result", got, exp);
                if (seen > 0) check("b2b_period", cyc - last, 35);
                else check("b2b_first_latency", cyc, 34);
                last = cyc;
                seen++;
                if (seen < 4) begin
                    bus.op = v_op[seen];
                    bus.a  = v_a[seen];
                    bus.b  = v_b[seen];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_count", seen, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
